seg7_time_scan: RTL and testbench
=================================

Name: seg7_time_scan

Overview:
- Display back-end directly downstream of the alarm-clock core.
- Consumes the six BCD time digits and the Alarm flag, and time-multiplexes them onto one common-anode 6-digit 7-segment display.
- Per frame: snapshot the digits, scan them with ghosting guard, blank the hour-tens leading zero, drive the colon DPs, and blink the whole display while Alarm is high.

Parameters:
- REFRESH_DIV, 50000: clk cycles per digit slot (≥ GUARD_CYCLES+2).
- GUARD_CYCLES, 4: cycles at the start of each slot with all anodes off (ghosting guard).
- BLINK_FRAMES, 64: full 6-digit frames per blink half-period.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-low reset.
- Hour_in1, in, 2: hour tens BCD.
- Hour_in0, in, 4: hour units BCD.
- Minute_in1, in, 4: minute tens BCD.
- Minute_in0, in, 4: minute units BCD.
- Second_in1, in, 4: second tens BCD.
- Second_in0, in, 4: second units BCD.
- Alarm_in, in, 1: alarm active; display blinks while high.
- seg, out, 7: {g,f,e,d,c,b,a}, active-low.
- dp, out, 1: decimal point, active-low.
- an, out, 6: digit anodes, active-low; an[k] selects digit k.

Behaviour:
- Reset (reset=0, async): an=6'b111111, seg=7'b1111111, dp=1, slot counter=0, digit index=0, blink phase=0, blink frame count=0, snapshot=all zero.
- Digit map: 0=Second_in0, 1=Second_in1, 2=Minute_in0, 3=Minute_in1, 4=Hour_in0, 5=Hour_in1 (zero-extended to 4 bits).
- Slot counter runs 0..REFRESH_DIV-1. On wrap, digit index advances 5→0 (wrap-around).
- Snapshot: all six digits are registered in the same cycle the index enters 0 (slot counter = 0, index = 0). Mid-frame input changes therefore never tear a frame.
- FSM per slot:
  - GUARD (counter < GUARD_CYCLES): an all 1; seg/dp updated for the new index.
  - DRIVE (remainder of the slot): an = ~(1<<index).
- Outputs are registered: seg/dp/an change one cycle after the counter/index state that selects them.
- Decode:
  - 0-9 use standard patterns, e.g. 0→1000000, 1→1111001, 7→1111000, 8→0000000.
  - Any value >9 → dash 0111111.
- Leading-zero blank: digit 5 with snapshot value 0 → seg=1111111 (the anode is still driven).
- dp=0 on digits 2 and 4 (colons), 1 elsewhere.
- Blink:
  - Frame count increments on each 5→0 wrap.
  - At BLINK_FRAMES-1 it clears and blink phase toggles.
  - While Alarm_in=1 and phase=1: an forced to all 1.
  - While Alarm_in=0: phase and frame count held at 0, so the display is always on and the first blink starts with an on half-period.
- Alarm_in rising mid-frame takes effect at the next cycle. Blanking never alters the scan cadence.
- Reset mid-frame: immediate return to the reset state. First slot after release is digit 0 with a fresh snapshot.

Optional Feature:
- Macro SEG7_BRIGHTNESS_PWM_EN.
- When defined:
  - Adds input brightness [3:0] and a free-running 4-bit PWM counter (reset 0).
  - In DRIVE, an is enabled only when pwm_cnt ≤ brightness, so 15 = full on and 0 = 1/16 duty.
  - brightness is sampled with the frame snapshot.
- When undefined: the port and counter are absent and DRIVE is always fully on.

Decomposition:
- Shared package clock_pkg:
  - SEG_* 7-bit pattern constants (digits 0-9, DASH, BLANK).
  - DIGIT_* index constants (0-5).
  - typedef bcd_t (4 bits).
- One sub-module: seg7_decode (combinational BCD→segment with blank input). It is instantiated once on the muxed snapshot digit.

Test Plan:
- Use REFRESH_DIV=8, GUARD_CYCLES=2, BLINK_FRAMES=2.
- Reset low mid-slot → an=111111, seg=1111111 and dp=1 within the same cycle. After release, the first DRIVE has an=111110.
- Inputs 1,2:3,4:5,6 → digit 5 seg=1111001; digit 0 seg=0000010; dp=0 only on digits 2 and 4. Each digit has 6 cycles with an low and 2 guard cycles with all anodes off.
- Hour 0,7, and Minute_in0 changes 3→8 during digit 3 → the current frame still shows 3. The next frame shows 8. Digit 5 is blank (seg=1111111).
- Minute_in1=4'hC → digit 3 seg=0111111 (dash).
- Alarm_in=1 for 8 frames → an all 1 during frames 3-4 and 7-8, normal elsewhere. Alarm_in=0 at frame 4 → anodes return next cycle.
- With SEG7_BRIGHTNESS_PWM_EN and brightness=3 → an low for 4 of every 16 DRIVE cycles. With brightness=15 → continuously low.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared constants for the alarm-clock display path: active-low 7-segment
// patterns ({g,f,e,d,c,b,a}), scan digit indices and the BCD digit type.
package clock_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [2:0] DIGIT_S0 = 3'd0;
  localparam logic [2:0] DIGIT_S1 = 3'd1;
  localparam logic [2:0] DIGIT_M0 = 3'd2;
  localparam logic [2:0] DIGIT_M1 = 3'd3;
  localparam logic [2:0] DIGIT_H0 = 3'd4;
  localparam logic [2:0] DIGIT_H1 = 3'd5;

endpackage

// File: rtl/seg7_time_scan_if.sv
// Time-digit / display bundle between the clock core (master) and the scan
// back-end (slave). Optional macro: SEG7_BRIGHTNESS_PWM_EN adds brightness.
interface seg7_time_scan_if;
  import clock_pkg::*;

  logic [1:0] Hour_in1;
  bcd_t       Hour_in0;
  bcd_t       Minute_in1;
  bcd_t       Minute_in0;
  bcd_t       Second_in1;
  bcd_t       Second_in0;
  logic       Alarm_in;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
`ifdef SEG7_BRIGHTNESS_PWM_EN
  logic [3:0] brightness;

  modport master (output Hour_in1, Hour_in0, Minute_in1, Minute_in0,
                         Second_in1, Second_in0, Alarm_in, brightness,
                  input  seg, dp, an);
  modport slave  (input  Hour_in1, Hour_in0, Minute_in1, Minute_in0,
                         Second_in1, Second_in0, Alarm_in, brightness,
                  output seg, dp, an);
`else
  modport master (output Hour_in1, Hour_in0, Minute_in1, Minute_in0,
                         Second_in1, Second_in0, Alarm_in,
                  input  seg, dp, an);
  modport slave  (input  Hour_in1, Hour_in0, Minute_in1, Minute_in0,
                         Second_in1, Second_in0, Alarm_in,
                  output seg, dp, an);
`endif

endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low segment decode; non-BCD shows a dash,
// blank overrides everything.
module seg7_decode
  import clock_pkg::*;
(
  input  bcd_t       digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Pattern lookup with blank override
  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/seg7_time_scan.sv
// Six-digit common-anode time display scanner with per-frame snapshot,
// ghosting guard, hour leading-zero blank, colon DPs and alarm blink.
// Optional macro: SEG7_BRIGHTNESS_PWM_EN (anode PWM dimming).
//
//   state    | meaning
//   ST_GUARD | first GUARD_CYCLES of a slot, all anodes off, seg/dp settle
//   ST_DRIVE | rest of the slot, anode of the current digit driven
module seg7_time_scan
  import clock_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 4,
  parameter int BLINK_FRAMES = 64
)(
  input  logic             clk,
  input  logic             reset,
  seg7_time_scan_if.slave  bus
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_LIM  = CW'(GUARD_CYCLES);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  localparam logic [0:0] ST_GUARD = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  logic [CW-1:0] slot_cnt;
  logic [2:0]    digit_idx;
  logic          blink_phase;
  logic [FW-1:0] frame_cnt;
  bcd_t          snap [6];
  logic [0:0]    slot_state;
  logic          frame_start, slot_wrap, frame_wrap;
  bcd_t          live [6];
  bcd_t          cur_digit;
  logic          lead_blank;
  logic [6:0]    dec_seg;
  logic [5:0]    an_next;
  logic [6:0]    seg_q;
  logic          dp_q;
  logic [5:0]    an_q;

  assign live[0] = bus.Second_in0;
  assign live[1] = bus.Second_in1;
  assign live[2] = bus.Minute_in0;
  assign live[3] = bus.Minute_in1;
  assign live[4] = bus.Hour_in0;
  assign live[5] = {2'b00, bus.Hour_in1};

  assign slot_state  = (slot_cnt < GUARD_LIM) ? ST_GUARD : ST_DRIVE;
  assign frame_start = (slot_cnt == '0) && (digit_idx == DIGIT_S0);
  assign slot_wrap   = (slot_cnt == SLOT_LAST);
  assign frame_wrap  = slot_wrap && (digit_idx == DIGIT_H1);

  // Digit select; frame-start cycle bypasses the snapshot being loaded
  always_comb begin
    cur_digit = '0;
    case (digit_idx)
      DIGIT_S0: cur_digit = frame_start ? live[0] : snap[0];
      DIGIT_S1: cur_digit = snap[1];
      DIGIT_M0: cur_digit = snap[2];
      DIGIT_M1: cur_digit = snap[3];
      DIGIT_H0: cur_digit = snap[4];
      DIGIT_H1: cur_digit = snap[5];
      default:  cur_digit = '0;
    endcase
  end

  assign lead_blank = (digit_idx == DIGIT_H1) && (cur_digit == '0);

  seg7_decode u_decode (
    .digit (cur_digit),
    .blank (lead_blank),
    .seg   (dec_seg)
  );

`ifdef SEG7_BRIGHTNESS_PWM_EN
  logic [3:0] pwm_cnt;
  logic [3:0] bright_snap;
  logic [3:0] bright_cur;

  assign bright_cur = frame_start ? bus.brightness : bright_snap;

  // Free-running PWM phase and per-frame brightness sample
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_cnt     <= '0;
      bright_snap <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
      if (frame_start) bright_snap <= bus.brightness;
    end
  end
`endif

  // Anode pattern for the current slot, then dimming and blink masks
  always_comb begin
    an_next = '1;
    if (slot_state == ST_DRIVE) an_next = ~(6'b000001 << digit_idx);
`ifdef SEG7_BRIGHTNESS_PWM_EN
    if (pwm_cnt > bright_cur) an_next = '1;
`endif
    if (bus.Alarm_in && blink_phase) an_next = '1;
  end

  // Slot counter and digit index scan cadence
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt  <= '0;
      digit_idx <= DIGIT_S0;
    end else if (slot_wrap) begin
      slot_cnt  <= '0;
      digit_idx <= (digit_idx == DIGIT_H1) ? DIGIT_S0 : digit_idx + 3'd1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // Blink phase; parked at the on half while alarm is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_phase <= 1'b0;
      frame_cnt   <= '0;
    end else if (!bus.Alarm_in) begin
      blink_phase <= 1'b0;
      frame_cnt   <= '0;
    end else if (frame_wrap) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Frame snapshot so mid-frame input changes never tear the display
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 6; i++) snap[i] <= '0;
    end else if (frame_start) begin
      for (int i = 0; i < 6; i++) snap[i] <= live[i];
    end
  end

  // Registered display outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
      an_q  <= '1;
    end else begin
      seg_q <= dec_seg;
      dp_q  <= ~((digit_idx == DIGIT_M0) || (digit_idx == DIGIT_H0));
      an_q  <= an_next;
    end
  end

  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;
  assign bus.an  = an_q;

endmodule

// File: tb/tb_seg7_time_scan.sv
// Self-checking bench for seg7_time_scan: table-driven digit frames, hand
// sequences for snapshot/blink/reset, and randomized traffic against a
// cycle-count based reference model.
module tb_seg7_time_scan;

  localparam int RD = 8;
  localparam int G  = 2;
  localparam int BF = 2;
  localparam int FR = 6 * RD;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  seg7_time_scan_if bus ();

  seg7_time_scan #(.REFRESH_DIV(RD), .GUARD_CYCLES(G), .BLINK_FRAMES(BF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state: cycles since reset release, snapshot, alarm wraps
  int k;
  int wraps;
  int snap [6];
  int snap_bright;
  logic [6:0] exp_seg;
  logic       exp_dp;
  logic [5:0] exp_an;

  logic [6:0] seen_seg [6];
  logic       seen_dp  [6];
  int         drive_cnt [6];
  int         lit_cycles;

  typedef struct {
    logic [1:0]      h1;
    logic [3:0]      h0, m1, m0, s1, s0;
    logic [5:0][6:0] segs;
  } vec_t;

  vec_t tbl [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] pat(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic int live_digit(input int i);
    case (i)
      0: return int'(bus.Second_in0);
      1: return int'(bus.Second_in1);
      2: return int'(bus.Minute_in0);
      3: return int'(bus.Minute_in1);
      4: return int'(bus.Hour_in0);
      default: return int'(bus.Hour_in1);
    endcase
  endfunction

  task automatic model_reset();
    k = 0;
    wraps = 0;
    snap_bright = 0;
    for (int i = 0; i < 6; i++) snap[i] = 0;
  endtask

  // expectation for the outputs registered at the coming edge
  task automatic model_step();
    int cnt, idx, v;
    bit phase;
    if (k % FR == 0) begin
      for (int i = 0; i < 6; i++) snap[i] = live_digit(i);
`ifdef SEG7_BRIGHTNESS_PWM_EN
      snap_bright = int'(bus.brightness);
`endif
    end
    cnt = k % RD;
    idx = (k / RD) % 6;
    v   = snap[idx];
    exp_seg = (idx == 5 && v == 0) ? 7'b1111111 : pat(v);
    exp_dp  = !(idx == 2 || idx == 4);
    phase   = ((wraps / BF) % 2) == 1;
    if (cnt < G) exp_an = 6'b111111;
    else         exp_an = ~(6'b000001 << idx);
`ifdef SEG7_BRIGHTNESS_PWM_EN
    if (cnt >= G && (k % 16) > snap_bright) exp_an = 6'b111111;
`endif
    if (bus.Alarm_in && phase) exp_an = 6'b111111;
    if (!bus.Alarm_in) wraps = 0;
    else if (k % FR == FR - 1) wraps++;
    k++;
  endtask

  task automatic cyc();
    model_step();
    @(negedge clk);
    check("scan", 32'({bus.an, bus.seg, bus.dp}), 32'({exp_an, exp_seg, exp_dp}));
    if (bus.an != 6'b111111) lit_cycles++;
    for (int i = 0; i < 6; i++) begin
      if (bus.an == ~(6'b000001 << i)) begin
        seen_seg[i] = bus.seg;
        seen_dp[i]  = bus.dp;
        drive_cnt[i]++;
      end
    end
  endtask

  task automatic clear_seen();
    lit_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      seen_seg[i]  = 7'b1010101;
      seen_dp[i]   = 1'bx;
      drive_cnt[i] = 0;
    end
  endtask

  task automatic to_frame_start();
    while (k % FR != 0) cyc();
  endtask

  task automatic set_time(input logic [1:0] h1, input logic [3:0] h0, input logic [3:0] m1,
                          input logic [3:0] m0, input logic [3:0] s1, input logic [3:0] s0);
    bus.Hour_in1   = h1;
    bus.Hour_in0   = h0;
    bus.Minute_in1 = m1;
    bus.Minute_in0 = m0;
    bus.Second_in1 = s1;
    bus.Second_in0 = s0;
  endtask

  initial begin
    bit found;
    tbl[0] = '{2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
               {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010}};
    tbl[1] = '{2'd0, 4'd7, 4'hC, 4'd9, 4'd0, 4'd8,
               {7'b1111111, 7'b1111000, 7'b0111111, 7'b0010000, 7'b1000000, 7'b0000000}};
    tbl[2] = '{2'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9,
               {7'b0100100, 7'b0110000, 7'b0010010, 7'b0010000, 7'b0010010, 7'b0010000}};
    tbl[3] = '{2'd3, 4'hF, 4'hF, 4'hA, 4'd0, 4'd1,
               {7'b0110000, 7'b0111111, 7'b0111111, 7'b0111111, 7'b1000000, 7'b1111001}};

    bus.Alarm_in = 1'b0;
`ifdef SEG7_BRIGHTNESS_PWM_EN
    bus.brightness = 4'd15;
`endif
    set_time(2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    clear_seen();
    repeat (3) @(negedge clk);
    check("reset_out", 32'({bus.an, bus.seg, bus.dp}), 32'({6'b111111, 7'b1111111, 1'b1}));
    reset = 1'b1;
    model_reset();

    // table-driven frames
    for (int t = 0; t < 4; t++) begin
      set_time(tbl[t].h1, tbl[t].h0, tbl[t].m1, tbl[t].m0, tbl[t].s1, tbl[t].s0);
      to_frame_start();
      clear_seen();
      repeat (FR) cyc();
      for (int d = 0; d < 6; d++) begin
        check($sformatf("tbl%0d_seg%0d", t, d), 32'(seen_seg[d]), 32'(tbl[t].segs[d]));
        check($sformatf("tbl%0d_dp%0d", t, d), 32'(seen_dp[d]), 32'((d == 2 || d == 4) ? 1'b0 : 1'b1));
        check($sformatf("tbl%0d_drive%0d", t, d), 32'(drive_cnt[d]), 32'(RD - G));
      end
      check($sformatf("tbl%0d_lit", t), 32'(lit_cycles), 32'(6 * (RD - G)));
    end

    // mid-frame input change does not tear the frame
    set_time(2'd0, 4'd7, 4'd1, 4'd3, 4'd0, 4'd0);
    to_frame_start();
    clear_seen();
    repeat (3 * RD + 3) cyc();
    bus.Minute_in0 = 4'd8;
    repeat (FR - 3 * RD - 3) cyc();
    check("tear_old_m0", 32'(seen_seg[2]), 32'(7'b0110000));
    check("tear_blank_h1", 32'(seen_seg[5]), 32'(7'b1111111));
    clear_seen();
    repeat (FR) cyc();
    check("tear_new_m0", 32'(seen_seg[2]), 32'(7'b0000000));

    // alarm blink over 8 frames
    to_frame_start();
    bus.Alarm_in = 1'b1;
    for (int f = 1; f <= 8; f++) begin
      clear_seen();
      repeat (FR) cyc();
      check($sformatf("blink_f%0d", f), 32'(lit_cycles),
            32'((f == 3 || f == 4 || f == 7 || f == 8) ? 0 : 6 * (RD - G)));
    end
    bus.Alarm_in = 1'b0;
    repeat (2) cyc();

    // alarm dropped during a dark frame: anodes back on the next cycle
    to_frame_start();
    bus.Alarm_in = 1'b1;
    repeat (3 * FR) cyc();
    repeat (2 * RD + 4) cyc();
    check("alarm_dark", 32'(bus.an), 32'(6'b111111));
    bus.Alarm_in = 1'b0;
    cyc();
    check("alarm_release", 32'(bus.an), 32'(6'b111011));

    // asynchronous reset mid-slot
    repeat (RD + 3) cyc();
    #2 reset = 1'b0;
    #1 check("async_reset", 32'({bus.an, bus.seg, bus.dp}), 32'({6'b111111, 7'b1111111, 1'b1}));
    @(negedge clk);
    check("reset_hold", 32'({bus.an, bus.seg, bus.dp}), 32'({6'b111111, 7'b1111111, 1'b1}));
    set_time(2'd2, 4'd1, 4'd4, 4'd2, 4'd3, 4'd9);
    reset = 1'b1;
    model_reset();
    found = 1'b0;
    for (int i = 0; i < 2 * RD && !found; i++) begin
      cyc();
      if (bus.an != 6'b111111) begin
        found = 1'b1;
        check("first_drive_an", 32'(bus.an), 32'(6'b111110));
        check("first_drive_seg", 32'(bus.seg), 32'(7'b0010000));
      end
    end
    if (!found) check("first_drive_timeout", 32'(bus.an), 32'(6'b111110));

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 5))
          0: bus.Hour_in1   = 2'($urandom_range(0, 3));
          1: bus.Hour_in0   = 4'($urandom_range(0, 15));
          2: bus.Minute_in1 = 4'($urandom_range(0, 15));
          3: bus.Minute_in0 = 4'($urandom_range(0, 15));
          4: bus.Second_in1 = 4'($urandom_range(0, 15));
          default: bus.Second_in0 = 4'($urandom_range(0, 15));
        endcase
      end
      if ($urandom_range(0, 199) == 0) bus.Alarm_in = ~bus.Alarm_in;
`ifdef SEG7_BRIGHTNESS_PWM_EN
      if ($urandom_range(0, 99) == 0) bus.brightness = 4'($urandom_range(0, 15));
`endif
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
